// File: rtl/jtag_debug_pkg.sv
// Shared definitions for the virtual-JTAG debug endpoint: IR opcodes and
// the saturating counter step.
package jtag_debug_pkg;

   localparam logic [2:0] OP_PUSH   = 3'b001;
   localparam logic [2:0] OP_POP    = 3'b010;
   localparam logic [2:0] OP_SELECT = 3'b011;
   localparam logic [2:0] OP_STATUS = 3'b100;

   // Holds at max_val instead of wrapping; callers zero-extend narrower counters.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
      return (val >= max_val) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/jtag_dr_shift.sv
// Generic data register for one virtual-JTAG opcode: parallel capture,
// LSB-first serial shift; capture wins over shift on the same edge.
module jtag_dr_shift #(
   parameter int N = 8
) (
   input  logic         tck,
   input  logic         reset,
   input  logic         cap_en,
   input  logic [N-1:0] cap_val,
   input  logic         shift_en,
   input  logic         tdi,
   output logic [N-1:0] q,
   output logic         lsb
);

   logic [N-1:0] sh_q, sh_d;

   // NOTE: every comb-assigned variable gets a default first so no latch is inferred.
   always_comb begin
      sh_d = sh_q;
      if (cap_en) begin
         sh_d = cap_val;
      end else if (shift_en) begin
         // Written as shift/or so N=1 elaborates without a reversed slice.
         sh_d = (sh_q >> 1) | (N'(tdi) << (N - 1));
      end
   end

   // NOTE: state is updated with non-blocking assignments only; reset is synchronous.
   always_ff @(posedge tck) begin
      if (reset) sh_q <= '0;
      else       sh_q <= sh_d;
   end

   assign q   = sh_q;
   assign lsb = sh_q[0];

endmodule

// File: rtl/jtag_debug_mux.sv
// Virtual-JTAG debug endpoint in the tck domain: PUSH control word, POP of a
// selected debug channel, SELECT of the channel, STATUS with saturating counters.
module jtag_debug_mux
   import jtag_debug_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2,
   parameter int CNT_W  = 8,
   parameter int IR_W   = 3
) (
   input  logic                    tck,
   input  logic                    reset,
   input  logic                    tdi,
   output logic                    tdo,
   input  logic [IR_W-1:0]         ir_in,
   input  logic                    vs_cdr,
   input  logic                    vs_sdr,
   input  logic                    vs_udr,
   input  logic [NUM_CH*WIDTH-1:0] in_debug,
   output logic [WIDTH-1:0]        push_data,
   output logic                    push_valid,
   output logic [SEL_W-1:0]        ch_sel
);

   localparam int ST_W = 2 * CNT_W + SEL_W;
   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   localparam logic [IR_W-1:0] IR_PUSH   = IR_W'(OP_PUSH);
   localparam logic [IR_W-1:0] IR_POP    = IR_W'(OP_POP);
   localparam logic [IR_W-1:0] IR_SELECT = IR_W'(OP_SELECT);
   localparam logic [IR_W-1:0] IR_STATUS = IR_W'(OP_STATUS);

   logic is_push, is_pop, is_sel, is_st;
   logic cdr_eff, sdr_eff, udr_eff;

   logic [WIDTH-1:0] push_data_q, push_data_d;
   logic             push_valid_q, push_valid_d;
   logic [SEL_W-1:0] ch_sel_q, ch_sel_d;
   logic [CNT_W-1:0] push_cnt_q, push_cnt_d;
   logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;

   logic [WIDTH-1:0] pop_cap;
   logic [WIDTH-1:0] sh_in, sh_out;
   logic [SEL_W-1:0] sh_sel;
   logic [ST_W-1:0]  sh_st;
   logic             sh_in_lsb, sh_out_lsb, sh_sel_lsb, sh_st_lsb;
   logic             unused_shift;

   assign is_push = (ir_in == IR_PUSH);
   assign is_pop  = (ir_in == IR_POP);
   assign is_sel  = (ir_in == IR_SELECT);
   assign is_st   = (ir_in == IR_STATUS);

   // A misbehaving primitive may raise several flags; cdr > sdr > udr.
   assign cdr_eff = vs_cdr;
   assign sdr_eff = vs_sdr & ~vs_cdr;
   assign udr_eff = vs_udr & ~vs_sdr & ~vs_cdr;

   // Out-of-range selects fall through to the zero default.
   always_comb begin
      pop_cap = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch_sel_q == SEL_W'(k)) pop_cap = in_debug[k*WIDTH +: WIDTH];
      end
   end

   jtag_dr_shift #(.N(WIDTH)) u_push_dr (
      .tck(tck), .reset(reset), .cap_en(1'b0), .cap_val('0),
      .shift_en(is_push & sdr_eff), .tdi(tdi), .q(sh_in), .lsb(sh_in_lsb)
   );

   jtag_dr_shift #(.N(WIDTH)) u_pop_dr (
      .tck(tck), .reset(reset), .cap_en(is_pop & cdr_eff), .cap_val(pop_cap),
      .shift_en(is_pop & sdr_eff), .tdi(tdi), .q(sh_out), .lsb(sh_out_lsb)
   );

   jtag_dr_shift #(.N(SEL_W)) u_sel_dr (
      .tck(tck), .reset(reset), .cap_en(1'b0), .cap_val('0),
      .shift_en(is_sel & sdr_eff), .tdi(tdi), .q(sh_sel), .lsb(sh_sel_lsb)
   );

   jtag_dr_shift #(.N(ST_W)) u_status_dr (
      .tck(tck), .reset(reset), .cap_en(is_st & cdr_eff),
      .cap_val({pop_cnt_q, push_cnt_q, ch_sel_q}),
      .shift_en(is_st & sdr_eff), .tdi(tdi), .q(sh_st), .lsb(sh_st_lsb)
   );

   // POP and STATUS are only ever read serially.
   assign unused_shift = ^{sh_out, sh_st};

   always_comb begin
      push_data_d  = push_data_q;
      push_valid_d = 1'b0;
      ch_sel_d     = ch_sel_q;
      push_cnt_d   = push_cnt_q;
      pop_cnt_d    = pop_cnt_q;
      if (is_push && udr_eff) begin
         push_data_d  = sh_in;
         push_valid_d = 1'b1;
         push_cnt_d   = CNT_W'(sat_inc(32'(push_cnt_q), CNT_MAX));
      end
      if (is_pop && cdr_eff) begin
         pop_cnt_d = CNT_W'(sat_inc(32'(pop_cnt_q), CNT_MAX));
      end
      if (is_sel && udr_eff) begin
         ch_sel_d = sh_sel;
      end
   end

   always_ff @(posedge tck) begin
      if (reset) begin
         push_data_q  <= '0;
         push_valid_q <= 1'b0;
         ch_sel_q     <= '0;
         push_cnt_q   <= '0;
         pop_cnt_q    <= '0;
      end else begin
         push_data_q  <= push_data_d;
         push_valid_q <= push_valid_d;
         ch_sel_q     <= ch_sel_d;
         push_cnt_q   <= push_cnt_d;
         pop_cnt_q    <= pop_cnt_d;
      end
   end

   always_comb begin
      tdo = tdi;
      if      (is_push) tdo = sh_in_lsb;
      else if (is_pop)  tdo = sh_out_lsb;
      else if (is_sel)  tdo = sh_sel_lsb;
      else if (is_st)   tdo = sh_st_lsb;
   end

   assign push_data  = push_data_q;
   assign push_valid = push_valid_q;
   assign ch_sel     = ch_sel_q;

endmodule
